// File: rtl/puncturer_pkg.sv
// =============================================================================
// puncturer_pkg : rate codes, puncturing periods and keep masks (802.11a)
// Revision      : 1.0
// =============================================================================
`default_nettype none

package puncturer_pkg;

    typedef enum logic [1:0] {
        RATE_1_2  = 2'd0,
        RATE_2_3  = 2'd1,
        RATE_3_4  = 2'd2,
        RATE_RSVD = 2'd3
    } rate_e;

    localparam int unsigned PHASE_W = 2;

    function automatic logic [PHASE_W-1:0] rate_period(input rate_e r);
        case (r)
            RATE_2_3: rate_period = 2'd2;
            RATE_3_4: rate_period = 2'd3;
            default:  rate_period = 2'd1;
        endcase
    endfunction

    // {keepA, keepB} for a given rate and phase; reserved rate behaves as 1/2
    function automatic logic [1:0] keep_mask(input rate_e r, input logic [PHASE_W-1:0] ph);
        keep_mask = 2'b11;
        case (r)
            RATE_2_3: keep_mask = (ph == 2'd1) ? 2'b10 : 2'b11;
            RATE_3_4: begin
                case (ph)
                    2'd1:    keep_mask = 2'b10;
                    2'd2:    keep_mask = 2'b01;
                    default: keep_mask = 2'b11;
                endcase
            end
            default:  keep_mask = 2'b11;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/puncturer_pattern.sv
// =============================================================================
// puncture_pattern : combinational keep mask, kept count and next phase
// Revision         : 1.0
// =============================================================================
`default_nettype none

module puncture_pattern
    import puncturer_pkg::*;
(
    input  rate_e              rate,
    input  logic [PHASE_W-1:0] phase,
    output logic [1:0]         keep,
    output logic [1:0]         kept_cnt,
    output logic [PHASE_W-1:0] next_phase
);

    logic [PHASE_W-1:0] w_period;

    always_comb begin
        w_period   = rate_period(rate);
        keep       = keep_mask(rate, phase);
        kept_cnt   = {1'b0, keep[1]} + {1'b0, keep[0]};
        next_phase = (phase >= w_period - 2'd1) ? '0 : phase + 2'd1;
    end

endmodule

`default_nettype wire

// File: rtl/puncturer.sv
// =============================================================================
// puncturer : drops coded bits per 802.11a pattern and repacks into 2-bit words
// Revision  : 1.0
// =============================================================================
`default_nettype none

module puncturer
    import puncturer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] rate,
    input  logic       in_valid,
    input  logic       a,
    input  logic       b,
    input  logic       flush,
    output logic [1:0] x,
    output logic       run,
    output logic       pad
);

    rate_e              r_rate;
    logic [PHASE_W-1:0] r_phase;
    logic               r_pend;     // buffer never holds more than one bit between cycles
    logic               r_cnt;
    logic [1:0]         r_x;
    logic               r_run;
    logic               r_pad;

    rate_e              w_rate;
    logic [PHASE_W-1:0] w_phase;
    logic               w_cnt;
    logic [1:0]         w_keep;
    logic [1:0]         w_kept_cnt;
    logic [PHASE_W-1:0] w_next_phase;
    logic [1:0]         w_kept;
    logic [2:0]         w_seq;
    logic [1:0]         w_total;

    // A start in the same cycle as a pair makes that pair phase 0 of the new frame
    always_comb begin
        w_rate  = start ? rate_e'(rate) : r_rate;
        w_phase = start ? '0 : r_phase;
        w_cnt   = start ? 1'b0 : r_cnt;
    end

    puncture_pattern u_pattern (
        .rate       (w_rate),
        .phase      (w_phase),
        .keep       (w_keep),
        .kept_cnt   (w_kept_cnt),
        .next_phase (w_next_phase)
    );

    // Surviving bits left-aligned, oldest at the MSB
    always_comb begin
        case (w_keep)
            2'b11:   w_kept = {a, b};
            2'b10:   w_kept = {a, 1'b0};
            2'b01:   w_kept = {b, 1'b0};
            default: w_kept = 2'b00;
        endcase
        w_seq   = w_cnt ? {r_pend, w_kept} : {w_kept, 1'b0};
        w_total = {1'b0, w_cnt} + w_kept_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rate  <= RATE_1_2;
            r_phase <= '0;
            r_pend  <= 1'b0;
            r_cnt   <= 1'b0;
            r_x     <= 2'b00;
            r_run   <= 1'b0;
            r_pad   <= 1'b0;
        end else begin
            r_run <= 1'b0;
            r_pad <= 1'b0;
            if (start) begin
                r_rate  <= rate_e'(rate);
                r_phase <= '0;
                r_pend  <= 1'b0;
                r_cnt   <= 1'b0;
            end
            if (in_valid) begin
                r_phase <= w_next_phase;
                if (w_total >= 2'd2) begin
                    r_x    <= w_seq[2:1];
                    r_run  <= 1'b1;
                    r_pend <= w_seq[0];
                    r_cnt  <= w_total[0];
                end else begin
                    r_pend <= w_seq[2];
                    r_cnt  <= w_total[0];
                end
            end else if (flush && !start) begin
                r_phase <= '0;
                if (r_cnt) begin
                    r_x   <= {r_pend, 1'b0};
                    r_run <= 1'b1;
                    r_pad <= 1'b1;
                end
                r_pend <= 1'b0;
                r_cnt  <= 1'b0;
            end
        end
    end

    assign x   = r_x;
    assign run = r_run;
    assign pad = r_pad;

endmodule

`default_nettype wire

// File: tb/tb_puncturer.sv
// =============================================================================
// tb_puncturer : directed stimulus, bit-queue reference model, literal checks
// Revision     : 1.0
// =============================================================================
`default_nettype none

module tb_puncturer;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, a, b, flush;
    logic [1:0] rate;
    logic [1:0] x;
    logic       run, pad;

    int checks = 0;
    int errors = 0;

    puncturer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rate     (rate),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .x        (x),
        .run      (run),
        .pad      (pad)
    );

    always #5 clk = ~clk;

    // Reference model: surviving bits go through a plain queue
    bit       q[$];
    int       m_rate  = 0;
    int       m_phase = 0;
    bit [1:0] e_x     = 2'b00;
    bit       e_run   = 1'b0;
    bit       e_pad   = 1'b0;

    function automatic int period_of(int r);
        return (r == 1) ? 2 : (r == 2) ? 3 : 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_rate = 0; m_phase = 0;
            e_x = 2'b00; e_run = 1'b0; e_pad = 1'b0;
        end else begin
            e_run = 1'b0; e_pad = 1'b0;
            if (start) begin
                q.delete();
                m_rate  = int'(rate);
                m_phase = 0;
            end
            if (in_valid) begin
                // phase 0 keeps both, phase 1 keeps A only, phase 2 keeps B only
                if (m_phase != 2) q.push_back(a);
                if (m_phase != 1) q.push_back(b);
                m_phase = (m_phase + 1) % period_of(m_rate);
                if (q.size() >= 2) begin
                    e_x   = {q[0], q[1]};
                    e_run = 1'b1;
                    void'(q.pop_front());
                    void'(q.pop_front());
                end
            end else if (flush && !start) begin
                if (q.size() == 1) begin
                    e_x   = {q[0], 1'b0};
                    e_run = 1'b1;
                    e_pad = 1'b1;
                end
                q.delete();
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if (x !== e_x) begin
            errors++;
            $display("FAIL model_x t=%0t: got %b expected %b", $time, x, e_x);
        end
        checks++;
        if (run !== e_run) begin
            errors++;
            $display("FAIL model_run t=%0t: got %b expected %b", $time, run, e_run);
        end
        checks++;
        if (pad !== e_pad) begin
            errors++;
            $display("FAIL model_pad t=%0t: got %b expected %b", $time, pad, e_pad);
        end
    end

    // One clock of stimulus; inputs return to idle just after the edge
    task automatic step(input bit v, input bit ia, input bit ib, input bit st,
                        input bit [1:0] rt, input bit fl, input bit rs);
        @(negedge clk);
        #1;
        in_valid = v; a = ia; b = ib; start = st; rate = rt; flush = fl; rst = rs;
        @(posedge clk);
        #1;
        in_valid = 1'b0; start = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    task automatic pair(input bit ia, input bit ib);
        step(1'b1, ia, ib, 1'b0, rate, 1'b0, 1'b0);
    endtask

    task automatic begin_frame(input bit [1:0] rt);
        step(1'b0, 1'b0, 1'b0, 1'b1, rt, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input string name, input bit [1:0] ex, input bit er, input bit ep);
        checks++;
        if (x !== ex || run !== er || pad !== ep) begin
            errors++;
            $display("FAIL %s: got x=%b run=%b pad=%b expected x=%b run=%b pad=%b",
                     name, x, run, pad, ex, er, ep);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rate = 2'd0; in_valid = 1'b0;
        a = 1'b0; b = 1'b0; flush = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        expect_out("reset", 2'b00, 1'b0, 1'b0);

        // rate 1/2
        begin_frame(2'd0);
        pair(1, 0); expect_out("r12_p1", 2'b10, 1, 0);
        pair(1, 1); expect_out("r12_p2", 2'b11, 1, 0);
        pair(0, 0); expect_out("r12_p3", 2'b00, 1, 0);
        pair(0, 1); expect_out("r12_p4", 2'b01, 1, 0);
        step(0, 0, 0, 0, 2'd0, 0, 0); expect_out("r12_idle", 2'b01, 0, 0);

        // rate 2/3, with a mid-frame rate change that must be ignored
        begin_frame(2'd1);
        pair(1, 0); expect_out("r23_p1", 2'b10, 1, 0);
        pair(1, 1); expect_out("r23_p2", 2'b10, 0, 0);
        rate = 2'd0;
        pair(0, 1); expect_out("r23_p3", 2'b10, 1, 0);
        pair(1, 0); expect_out("r23_p4", 2'b11, 1, 0);

        // rate 3/4 with phase wrap
        begin_frame(2'd2);
        pair(1, 1); expect_out("r34_p1", 2'b11, 1, 0);
        pair(0, 1); expect_out("r34_p2", 2'b11, 0, 0);
        pair(1, 0); expect_out("r34_p3", 2'b00, 1, 0);
        pair(1, 0); expect_out("r34_wrap", 2'b10, 1, 0);

        // flush of a pending bit, then an empty flush
        begin_frame(2'd1);
        pair(1, 1); expect_out("fl_p1", 2'b11, 1, 0);
        pair(1, 0); expect_out("fl_p2", 2'b11, 0, 0);
        step(0, 0, 0, 0, 2'd1, 1, 0); expect_out("flush1", 2'b10, 1, 1);
        step(0, 0, 0, 0, 2'd1, 1, 0); expect_out("flush2", 2'b10, 0, 0);

        // start with a pair discards the pending bit; flush with valid ignored
        begin_frame(2'd1);
        pair(1, 1); expect_out("st_p1", 2'b11, 1, 0);
        pair(0, 0); expect_out("st_p2", 2'b11, 0, 0);
        step(1, 0, 1, 1, 2'd0, 0, 0); expect_out("st_pair", 2'b01, 1, 0);
        step(1, 1, 1, 0, 2'd0, 1, 0); expect_out("fl_valid", 2'b11, 1, 0);

        // flush with valid at 2/3 while a bit is pending: pair still processed
        begin_frame(2'd1);
        pair(0, 1); expect_out("fv_p1", 2'b01, 1, 0);
        pair(1, 1); expect_out("fv_p2", 2'b01, 0, 0);
        step(1, 0, 1, 0, 2'd1, 1, 0); expect_out("fv_p3", 2'b10, 1, 0);

        // reserved rate code behaves as 1/2
        begin_frame(2'd3);
        pair(0, 1); expect_out("r3_p1", 2'b01, 1, 0);
        pair(1, 0); expect_out("r3_p2", 2'b10, 1, 0);

        // reset mid-frame with a pending bit
        begin_frame(2'd2);
        pair(1, 1); expect_out("rst_p1", 2'b11, 1, 0);
        pair(1, 0); expect_out("rst_p2", 2'b11, 0, 0);
        step(1, 1, 1, 1, 2'd1, 0, 1); expect_out("rst_mid", 2'b00, 0, 0);
        pair(1, 0); expect_out("rst_after1", 2'b10, 1, 0);
        pair(0, 1); expect_out("rst_after2", 2'b01, 1, 0);

        step(0, 0, 0, 0, 2'd0, 0, 0);
        @(negedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
